// File: rtl/wb_arbiter.sv
// Write-back arbiter: three producer FIFOs (alu/fpu/mem) drained onto two register-file
// write ports with round-robin priority, same-address conflict avoidance and pending-write lookup.
module wb_arbiter #(
  parameter int DEPTH     = 2,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter bit DROP_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              fpu_valid,
  output logic              fpu_ready,
  input  logic [ADDR_W-1:0] fpu_addr,
  input  logic [DATA_W-1:0] fpu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              we1,
  output logic [ADDR_W-1:0] aw1,
  output logic [DATA_W-1:0] wd1,
  output logic              we2,
  output logic [ADDR_W-1:0] aw2,
  output logic [DATA_W-1:0] wd2,
  input  logic [ADDR_W-1:0] q1_addr,
  input  logic [ADDR_W-1:0] q2_addr,
  output logic              q1_hit,
  output logic              q2_hit,
  output logic              busy
);

  localparam int NSRC  = 3;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [NSRC-1:0]   in_valid;
  logic [NSRC-1:0]   in_ready;
  logic [NSRC-1:0]   push;
  logic [NSRC-1:0]   pop;
  logic [NSRC-1:0]   head_valid;
  logic [NSRC-1:0]   hit1_src;
  logic [NSRC-1:0]   hit2_src;
  logic [ADDR_W-1:0] in_addr   [NSRC];
  logic [DATA_W-1:0] in_data   [NSRC];
  logic [ADDR_W-1:0] head_addr [NSRC];
  logic [DATA_W-1:0] head_data [NSRC];

  assign in_valid   = {mem_valid, fpu_valid, alu_valid};
  assign in_addr[0] = alu_addr;
  assign in_addr[1] = fpu_addr;
  assign in_addr[2] = mem_addr;
  assign in_data[0] = alu_data;
  assign in_data[1] = fpu_data;
  assign in_data[2] = mem_data;
  assign alu_ready  = in_ready[0];
  assign fpu_ready  = in_ready[1];
  assign mem_ready  = in_ready[2];

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_fifo
      logic [ADDR_W-1:0] addr_mem [DEPTH];
      logic [DATA_W-1:0] data_mem [DEPTH];
      logic [DEPTH-1:0]  ent_valid_reg;
      logic [DEPTH-1:0]  ent_valid_next;
      logic [PTR_W-1:0]  rd_ptr_reg;
      logic [PTR_W-1:0]  wr_ptr_reg;
      logic [CNT_W-1:0]  count_reg;
      logic              hit1;
      logic              hit2;

      // Ready looks only at the pre-pop count, so a full FIFO never accepts while draining.
      assign in_ready[gi]   = !rst && (count_reg < CNT_W'(DEPTH));
      assign push[gi]       = in_valid[gi] && in_ready[gi];
      assign head_valid[gi] = (count_reg != '0);
      assign head_addr[gi]  = addr_mem[rd_ptr_reg];
      assign head_data[gi]  = data_mem[rd_ptr_reg];

      always_comb begin
        ent_valid_next = ent_valid_reg;
        if (pop[gi]) begin
          ent_valid_next[rd_ptr_reg] = 1'b0;
        end
        if (push[gi]) begin
          ent_valid_next[wr_ptr_reg] = 1'b1;
        end
      end

      always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_valid_reg[i] && !(DROP_ZERO && (addr_mem[i] == '0))) begin
            if (addr_mem[i] == q1_addr) hit1 = 1'b1;
            if (addr_mem[i] == q2_addr) hit2 = 1'b1;
          end
        end
      end

      assign hit1_src[gi] = hit1;
      assign hit2_src[gi] = hit2;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_ptr_reg    <= '0;
          wr_ptr_reg    <= '0;
          count_reg     <= '0;
          ent_valid_reg <= '0;
        end else begin
          if (push[gi]) begin
            addr_mem[wr_ptr_reg] <= in_addr[gi];
            data_mem[wr_ptr_reg] <= in_data[gi];
            wr_ptr_reg           <= ptr_inc(wr_ptr_reg);
          end
          if (pop[gi]) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
          end
          count_reg     <= count_reg + CNT_W'(push[gi]) - CNT_W'(pop[gi]);
          ent_valid_reg <= ent_valid_next;
        end
      end
    end
  endgenerate

  logic [1:0]        rr_reg;
  logic              sel1;
  logic              sel2;
  logic [1:0]        src1;
  logic [1:0]        src2;
  logic [1:0]        scan;
  logic              drop1;
  logic              drop2;
  logic              we1_reg;
  logic              we2_reg;
  logic [ADDR_W-1:0] aw1_reg;
  logic [ADDR_W-1:0] aw2_reg;
  logic [DATA_W-1:0] wd1_reg;
  logic [DATA_W-1:0] wd2_reg;

  // Scan heads starting at rr; port 2 takes the next head whose address differs from port 1.
  always_comb begin
    sel1 = 1'b0;
    sel2 = 1'b0;
    src1 = 2'd0;
    src2 = 2'd0;
    scan = rr_reg;
    for (int k = 0; k < NSRC; k++) begin
      if (head_valid[scan]) begin
        if (!sel1) begin
          sel1 = 1'b1;
          src1 = scan;
        end else if (!sel2 && (head_addr[scan] != head_addr[src1])) begin
          sel2 = 1'b1;
          src2 = scan;
        end
      end
      scan = (scan == 2'd2) ? 2'd0 : scan + 2'd1;
    end
  end

  always_comb begin
    pop = '0;
    if (sel1) pop[src1] = 1'b1;
    if (sel2) pop[src2] = 1'b1;
  end

  assign drop1 = DROP_ZERO && (head_addr[src1] == '0);
  assign drop2 = DROP_ZERO && (head_addr[src2] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_reg  <= 2'd0;
      we1_reg <= 1'b0;
      we2_reg <= 1'b0;
      aw1_reg <= '0;
      aw2_reg <= '0;
      wd1_reg <= '0;
      wd2_reg <= '0;
    end else begin
      we1_reg <= sel1 && !drop1;
      we2_reg <= sel2 && !drop2;
      if (sel1) begin
        aw1_reg <= head_addr[src1];
        wd1_reg <= head_data[src1];
        rr_reg  <= (src1 == 2'd2) ? 2'd0 : src1 + 2'd1;
      end
      if (sel2) begin
        aw2_reg <= head_addr[src2];
        wd2_reg <= head_data[src2];
      end
    end
  end

  assign we1    = we1_reg;
  assign we2    = we2_reg;
  assign aw1    = aw1_reg;
  assign aw2    = aw2_reg;
  assign wd1    = wd1_reg;
  assign wd2    = wd2_reg;
  assign q1_hit = |hit1_src;
  assign q2_hit = |hit2_src;
  assign busy   = (|head_valid) || we1_reg || we2_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: single write, arbitration, conflicts, backpressure,
// pending lookup, zero-address drop and mid-operation reset.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, fpu_valid, mem_valid;
  logic        alu_ready, fpu_ready, mem_ready;
  logic [5:0]  alu_addr, fpu_addr, mem_addr;
  logic [31:0] alu_data, fpu_data, mem_data;
  logic        we1, we2;
  logic [5:0]  aw1, aw2;
  logic [31:0] wd1, wd2;
  logic [5:0]  q1_addr, q2_addr;
  logic        q1_hit, q2_hit;
  logic        busy;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_addr(fpu_addr), .fpu_data(fpu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .we1(we1), .aw1(aw1), .wd1(wd1), .we2(we2), .aw2(aw2), .wd2(wd2),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_hit(q1_hit), .q2_hit(q2_hit), .busy(busy)
  );

  int tests = 0;
  int fails = 0;
  int writes_seen;
  logic [63:0] q_alu[$];
  logic [63:0] q_fpu[$];
  logic [63:0] q_mem[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    fpu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic set_src(input int s, input logic [5:0] a, input logic [31:0] d);
    case (s)
      0: begin alu_valid = 1'b1; alu_addr = a; alu_data = d; end
      1: begin fpu_valid = 1'b1; fpu_addr = a; fpu_data = d; end
      default: begin mem_valid = 1'b1; mem_addr = a; mem_data = d; end
    endcase
  endtask

  function automatic logic src_ready(input int s);
    case (s)
      0: return alu_ready;
      1: return fpu_ready;
      default: return mem_ready;
    endcase
  endfunction

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("rst_ready_low", 64'({alu_ready, fpu_ready, mem_ready}), 64'd0);
    check("rst_we_busy_hit", 64'({we1, we2, busy, q1_hit, q2_hit}), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 64'({alu_ready, fpu_ready, mem_ready}), 64'b111);
  endtask

  // Scoreboard for a write seen on a port: source recovered from the data tag.
  task automatic sb_write(input logic [5:0] a, input logic [31:0] d);
    logic [63:0] e;
    int s;
    s = int'(d[31:28]);
    writes_seen++;
    e = 64'hDEAD_BEEF_DEAD_BEEF;
    case (s)
      0: if (q_alu.size() > 0) e = q_alu.pop_front();
      1: if (q_fpu.size() > 0) e = q_fpu.pop_front();
      2: if (q_mem.size() > 0) e = q_mem.pop_front();
      default: e = 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
    check("t4_write", 64'({a, d}), e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  a;
    logic [31:0] d;
    int          seq [3];
    int          bad_rate;
    int          pushes;
    int          quiet_bad;
    bit          saw_nr;

    rst = 1'b1;
    idle_inputs();
    alu_addr = '0; fpu_addr = '0; mem_addr = '0;
    alu_data = '0; fpu_data = '0; mem_data = '0;
    q1_addr = '0;  q2_addr = '0;

    // T1 single write
    do_reset();
    check("rst_aw_wd", 64'({aw1, aw2, wd1, wd2} != '0), 64'd0);
    set_src(0, 6'd5, 32'h11);
    step();
    idle_inputs();
    check("t1_buffered_busy", 64'({we1, busy}), 64'b01);
    step();
    check("t1_port1", 64'({we1, aw1, wd1}), 64'({1'b1, 6'd5, 32'h11}));
    check("t1_we2", 64'(we2), 64'd0);
    step();
    check("t1_idle", 64'({we1, we2, busy}), 64'd0);

    // T2 three-way arbitration from rr=0
    do_reset();
    set_src(0, 6'd1, 32'hAAAA_0001);
    set_src(1, 6'd2, 32'hBBBB_0002);
    set_src(2, 6'd3, 32'hCCCC_0003);
    step();
    idle_inputs();
    step();
    check("t2_c1_p1", 64'({we1, aw1, wd1}), 64'({1'b1, 6'd1, 32'hAAAA_0001}));
    check("t2_c1_p2", 64'({we2, aw2, wd2}), 64'({1'b1, 6'd2, 32'hBBBB_0002}));
    set_src(0, 6'd4, 32'h0000_0044);
    set_src(1, 6'd5, 32'h0000_0055);
    step();
    idle_inputs();
    check("t2_c2_p1", 64'({we1, aw1, wd1}), 64'({1'b1, 6'd3, 32'hCCCC_0003}));
    check("t2_c2_we2", 64'(we2), 64'd0);
    step();
    check("t2_rr0_p1", 64'({we1, aw1}), 64'({1'b1, 6'd4}));
    check("t2_rr0_p2", 64'({we2, aw2}), 64'({1'b1, 6'd5}));

    // T3 address conflict
    do_reset();
    set_src(0, 6'd7, 32'h0000_00A7);
    set_src(1, 6'd7, 32'h0000_00B7);
    set_src(2, 6'd9, 32'h0000_00C9);
    step();
    idle_inputs();
    step();
    check("t3_c1_p1", 64'({we1, aw1, wd1}), 64'({1'b1, 6'd7, 32'h0000_00A7}));
    check("t3_c1_p2", 64'({we2, aw2, wd2}), 64'({1'b1, 6'd9, 32'h0000_00C9}));
    step();
    check("t3_c2_p1", 64'({we1, aw1, wd1}), 64'({1'b1, 6'd7, 32'h0000_00B7}));
    check("t3_c2_we2", 64'(we2), 64'd0);

    // T4 backpressure with tagged data
    do_reset();
    seq = '{0, 0, 0};
    bad_rate = 0;
    pushes = 0;
    saw_nr = 1'b0;
    writes_seen = 0;
    for (int c = 0; c < 13; c++) begin
      if (we1) sb_write(aw1, wd1);
      if (we2) sb_write(aw2, wd2);
      if (c >= 2 && (int'(we1) + int'(we2)) != 2) bad_rate++;
      idle_inputs();
      if (c < 12) begin
        for (int s = 0; s < 3; s++) begin
          a = 6'(8 + 16 * s + seq[s] % 8);
          d = {4'(s), 28'(seq[s])};
          set_src(s, a, d);
          if (src_ready(s)) begin
            case (s)
              0: q_alu.push_back(64'({a, d}));
              1: q_fpu.push_back(64'({a, d}));
              default: q_mem.push_back(64'({a, d}));
            endcase
            seq[s]++;
            pushes++;
          end else begin
            saw_nr = 1'b1;
          end
        end
      end
      step();
    end
    idle_inputs();
    for (int c = 0; c < 20; c++) begin
      if (we1) sb_write(aw1, wd1);
      if (we2) sb_write(aw2, wd2);
      step();
    end
    check("t4_ready_dropped", 64'(saw_nr), 64'd1);
    check("t4_rate_bad_cycles", 64'(bad_rate), 64'd0);
    check("t4_leftover", 64'(q_alu.size() + q_fpu.size() + q_mem.size()), 64'd0);
    check("t4_write_count", 64'(writes_seen), 64'(pushes));
    check("t4_drained", 64'(busy), 64'd0);

    // T5a pending lookup on a mem entry queued behind other traffic
    do_reset();
    q1_addr = 6'd40;
    q2_addr = 6'd12;
    set_src(0, 6'd10, 32'h0000_0010);
    set_src(1, 6'd11, 32'h0000_0011);
    set_src(2, 6'd40, 32'hD0D0_0040);
    check("t5_hit_empty", 64'({q1_hit, q2_hit}), 64'd0);
    step();
    idle_inputs();
    check("t5_hit_buffered", 64'(q1_hit), 64'd1);
    set_src(0, 6'd12, 32'h0000_0012);
    set_src(1, 6'd13, 32'h0000_0013);
    step();
    idle_inputs();
    check("t5_hit_still", 64'({q1_hit, q2_hit}), 64'b11);
    check("t5_first_pair", 64'({aw1, aw2}), 64'({6'd10, 6'd11}));
    step();
    check("t5_hit_cleared", 64'(q1_hit), 64'd0);
    check("t5_p1_fpu", 64'({we1, aw1}), 64'({1'b1, 6'd13}));
    check("t5_p2_mem", 64'({we2, aw2, wd2}), 64'({1'b1, 6'd40, 32'hD0D0_0040}));

    // T5b zero-address drop
    do_reset();
    q1_addr = 6'd0;
    set_src(0, 6'd0, 32'hEEEE_0000);
    step();
    idle_inputs();
    check("t5b_zero_hit_busy", 64'({q1_hit, busy}), 64'b01);
    step();
    check("t5b_no_we", 64'({we1, we2}), 64'd0);
    check("t5b_popped", 64'(busy), 64'd0);

    // T6 reset mid-operation
    do_reset();
    set_src(0, 6'd20, 32'h0000_0020);
    set_src(1, 6'd21, 32'h0000_0021);
    set_src(2, 6'd22, 32'h0000_0022);
    step();
    set_src(0, 6'd23, 32'h0000_0023);
    set_src(1, 6'd24, 32'h0000_0024);
    set_src(2, 6'd25, 32'h0000_0025);
    step();
    idle_inputs();
    check("t6_pre_write", 64'({we1, aw1}), 64'({1'b1, 6'd20}));
    q1_addr = 6'd25;
    q2_addr = 6'd22;
    rst = 1'b1;
    step();
    check("t6_rst_out", 64'({we1, we2, busy, q1_hit, q2_hit}), 64'd0);
    check("t6_rst_ready", 64'({alu_ready, fpu_ready, mem_ready}), 64'd0);
    rst = 1'b0;
    #1;
    check("t6_ready_after", 64'({alu_ready, fpu_ready, mem_ready}), 64'b111);
    quiet_bad = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (we1 || we2 || busy || q1_hit || q2_hit) quiet_bad++;
    end
    check("t6_quiet_cycles_bad", 64'(quiet_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
